fifo_word_unpacker: RTL
=======================

# fifo_word_unpacker

Downstream consumer stage for the flip-flop FIFO. It pops wide words from the FIFO's show-ahead read port and emits each word as `n_parts` narrow parts on a valid/ready stream. When the FIFO is non-empty and the sink is always ready, it sustains one part per cycle with no bubble between words. It attaches directly to the FIFO's `pop`, `read_data` and `empty` signals.

## Interface
- `part_width`, default 8: width of one output part in bits.
- `n_parts`, default 4: number of parts per FIFO word. Must be ≥ 2.
- `msb_first`, default 0: emission order. 0 emits part 0 (the least significant part) first; 1 emits the most significant part first.
- Derived: `word_width = part_width * n_parts`; `idx_width = $clog2(n_parts)`.
- `clk`  in  1  single clock. Everything is on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_read_data`  in  word_width  FIFO show-ahead head word. Valid whenever `fifo_empty` = 0.
- `fifo_pop`  out  1  pop request to the FIFO. Combinational.
- `out_valid`  out  1  an output part is available.
- `out_ready`  in  1  the sink accepts the part.
- `out_data`  out  part_width  current part.
- `out_last`  out  1  current part is the final part of its word.
- `busy`  out  1  a word is held in the block (`state` = LOADED).

## Operation
- State machine with two states:
  - EMPTY: no word held.
  - LOADED: `word_q` holds a word; index `idx_q` selects the current part.
- `fifo_pop` is asserted when `fifo_empty` = 0 and either of these holds:
  - `state` = EMPTY;
  - `state` = LOADED, `out_valid & out_ready`, and `idx_q == n_parts-1`.
- `fifo_pop` is never asserted while `fifo_empty` = 1.
- On `fifo_pop`: `word_q <= fifo_read_data`, `idx_q <= 0`, `state <= LOADED`.
- LOADED with `out_valid & out_ready`:
  - If `idx_q < n_parts-1`: `idx_q <= idx_q + 1`.
  - Otherwise, if no pop occurs this cycle: `state <= EMPTY`.
- Outputs:
  - `out_valid = (state == LOADED)`.
  - `out_data` is part `idx_q` of `word_q` when `msb_first` = 0, and part `n_parts-1-idx_q` when `msb_first` = 1.
  - `out_last = out_valid & (idx_q == n_parts-1)`.
- `out_data` and `out_last` stay stable while `out_valid & ~out_ready`. The block never drops a part and never repeats one.
- The `idx_q` increment never wraps past `n_parts-1`. Reload is the only path back to 0, including for non-power-of-two `n_parts`.
- Reset values:
  - `state` = EMPTY, `idx_q` = 0, `word_q` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `busy` = 0.
  - `fifo_pop` = 0 while `rst` = 0.

## Timing
- Latency: a word present at the FIFO head in cycle N (with `state` = EMPTY) is popped in cycle N. Its first part is on `out_data` with `out_valid` = 1 in cycle N+1.
- Sustained throughput: 1 part per cycle. A word takes `n_parts` cycles when `out_ready` = 1.
- Last-part accept and next-word pop happen in the same cycle. The first part of the next word appears in the following cycle, with no idle cycle between words.
- `fifo_pop` depends combinationally on `out_ready`. This path is accepted. The FIFO registers on `pop`, so no loop is formed.
- Last part accepted with the FIFO empty: `out_valid` = 0 in the next cycle. A push to the FIFO in that same cycle is popped one cycle later (EMPTY path).
- Reset asserted mid-word forces `out_valid` = 0 immediately (asynchronous). The remaining parts of the held word are discarded. FIFO contents are untouched by this block.

## Structure
- Package `fifo_word_unpacker_pkg` holds:
  - the state typedef `unpack_state_t` (EMPTY, LOADED);
  - no other shared constants. Widths are derived from parameters inside the module.
- Single module; no sub-module. The part selection is an indexed part-select on `word_q`.
- The FIFO is instantiated by the parent, not inside this block.

## Test plan
All scenarios use `part_width` = 8, `n_parts` = 4 unless stated.
- Idle: release reset with `fifo_empty` = 1 for 20 cycles -> `out_valid` = 0, `fifo_pop` = 0, `out_data` = 0 throughout.
- Single word: `fifo_read_data` = 32'h44332211 shown in cycle 0, `out_ready` = 1 -> `fifo_pop` = 1 in cycle 0 only; `out_data` = 11, 22, 33, 44 in cycles 1–4; `out_last` = 1 only in cycle 4; `out_valid` = 0 in cycle 5.
- Back-to-back: words 32'h44332211 then 32'h88776655 in the FIFO, `out_ready` = 1 -> 8 consecutive beats 11…88 with no gap; the second `fifo_pop` occurs in the same cycle the beat 44 is accepted.
- Backpressure: same single word, `out_ready` = 0 in cycles 2–4 -> `out_data` = 22 held for cycles 2–5 with `out_valid` = 1; beats 33 and 44 follow in cycles 6–7; no pop in between.
- Reset mid-word: assert `rst` = 0 after beats 11 and 22 are accepted -> `out_valid` = 0 within the same cycle, `fifo_pop` = 0; after release with the next word 32'hDDCCBBAA at the head -> beats AA, BB, CC, DD.
- Order: `msb_first` = 1, word 32'h44332211 -> beats 44, 33, 22, 11 with `out_last` on 11.

Source files
------------

// File: rtl/fifo_word_unpacker_pkg.sv
// rtl/fifo_word_unpacker_pkg.sv - shared state type for the FIFO word unpacker
package fifo_word_unpacker_pkg;

   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } unpack_state_t;

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// rtl/fifo_word_unpacker_if.sv - FIFO read port plus narrow part stream
interface fifo_word_unpacker_if #(
   parameter int part_width = 8,
   parameter int n_parts    = 4
);
   localparam int word_width = part_width * n_parts;

   logic                  fifo_empty;
   logic [word_width-1:0] fifo_read_data;
   logic                  fifo_pop;
   logic                  out_valid;
   logic                  out_ready;
   logic [part_width-1:0] out_data;
   logic                  out_last;

   modport master (
      input  fifo_empty, fifo_read_data, out_ready,
      output fifo_pop, out_valid, out_data, out_last
   );

   modport slave (
      output fifo_empty, fifo_read_data, out_ready,
      input  fifo_pop, out_valid, out_data, out_last
   );

endinterface

// File: rtl/fifo_word_unpacker.sv
// rtl/fifo_word_unpacker.sv - pops wide FIFO words and emits them as n_parts narrow beats
module fifo_word_unpacker
   import fifo_word_unpacker_pkg::*;
#(
   parameter int part_width = 8,
   parameter int n_parts    = 4,
   parameter bit msb_first  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_word_unpacker_if.master bus,
   output logic                 busy
);
   localparam int word_width = part_width * n_parts;
   localparam int idx_width  = $clog2(n_parts);
   localparam logic [idx_width-1:0] last_idx = idx_width'(n_parts - 1);

   unpack_state_t         state_q, state_d;
   logic [idx_width-1:0]  idx_q, idx_d, part_sel;
   logic [word_width-1:0] word_q, word_d;
   logic                  at_last, accept, pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         idx_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      at_last = (idx_q == last_idx);
      accept  = (state_q == LOADED) && bus.out_ready;
      // Popping on the last-part accept is what removes the bubble between words.
      pop     = !bus.fifo_empty && ((state_q == EMPTY) || (accept && at_last));
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      if (pop) begin
         word_d  = bus.fifo_read_data;
         idx_d   = '0;
         state_d = LOADED;
      end else if (accept) begin
         if (!at_last) begin
            idx_d = idx_q + 1'b1;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   always_comb begin
      part_sel      = msb_first ? (last_idx - idx_q) : idx_q;
      bus.out_data  = word_q[int'(part_sel) * part_width +: part_width];
      bus.out_valid = (state_q == LOADED);
      bus.out_last  = (state_q == LOADED) && at_last;
      // Gate with reset so the FIFO never sees a pop while this block is held in reset.
      bus.fifo_pop  = pop && rst;
      busy          = (state_q == LOADED);
   end

endmodule
